// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency data memory for the MEM stage, stalling the pipeline until ready
module data_mem_responder #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   input  logic        memRead,
   input  logic        memWrite,
   output logic [31:0] readData,
   output logic        ready,
   output logic        stall,
   output logic        err
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t            state;
   logic [3:0]        cnt;
   logic [ADDR_W-1:0] idx;
   logic [31:0]       wdata;
   logic              is_write;
   logic              bad;
   logic [31:0]       mem [2**ADDR_W];
   logic              unused_addr;
   assign unused_addr = ^address[31:ADDR_W+2];
   assign stall = (memRead | memWrite) & ~ready;
   // request FSM: latch on accept, count down the latency, commit and pulse ready for one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         idx      <= '0;
         wdata    <= '0;
         is_write <= 1'b0;
         bad      <= 1'b0;
         ready    <= 1'b0;
         err      <= 1'b0;
         readData <= '0;
         for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
      end else begin
         case (state)
            IDLE: if (memRead | memWrite) begin
               state    <= BUSY;
               cnt      <= 4'(LATENCY - 1);
               idx      <= address[ADDR_W+1:2];
               wdata    <= writeData;
               is_write <= memWrite;
               bad      <= (address[1:0] != 2'b00) | (memRead & memWrite);
            end
            BUSY: if (cnt == 4'd0) begin
               state <= DONE;
               ready <= 1'b1;
               err   <= bad;
               if (!bad && is_write) mem[idx] <= wdata;
               if (!bad && !is_write) readData <= mem[idx];
            end else begin
               cnt <= cnt - 4'd1;
            end
            default: begin
               state    <= IDLE;
               ready    <= 1'b0;
               err      <= 1'b0;
               readData <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized scoreboard bench for the fixed-latency data memory
module tb_data_mem_responder;
   localparam int L = 2;
   logic        clk = 0;
   logic        rst = 1;
   logic [31:0] address = 0;
   logic [31:0] writeData = 0;
   logic        memRead = 0;
   logic        memWrite = 0;
   logic [31:0] readData;
   logic        ready;
   logic        stall;
   logic        err;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [32:0] sb [$];
   logic [31:0] model [256];

   data_mem_responder #(.ADDR_W(8), .LATENCY(L)) dut (
      .clk(clk), .rst(rst), .address(address), .writeData(writeData),
      .memRead(memRead), .memWrite(memWrite), .readData(readData),
      .ready(ready), .stall(stall), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: every ready cycle is matched against the oldest expected response
   always @(negedge clk) begin
      if (!rst && ready) begin
         logic [32:0] e;
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_ready: got ready=1 err=%b data=%h expected no response", err, readData);
         end else begin
            e = sb.pop_front();
            if ({err, readData} !== e) begin
               n_fail++;
               $display("FAIL response: got err=%b data=%h expected err=%b data=%h", err, readData, e[32], e[31:0]);
            end
         end
      end
   end

   // reference: what the memory should return for a request, updating the model on clean stores
   task automatic expect_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      logic e;
      logic [31:0] v;
      e = (a[1:0] != 0) || (rd && wr);
      v = (!e && rd) ? model[a[9:2]] : 32'h0;
      if (!e && wr) model[a[9:2]] = d;
      sb.push_back({e, v});
   endtask

   task automatic do_reset();
      rst = 1; memRead = 0; memWrite = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      for (int i = 0; i < 256; i++) model[i] = 0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      do begin
         @(posedge clk); #1 n++;
         if (!ready) check("stall_while_waiting", {31'b0, stall}, 32'd1);
      end while (!ready && n < 30);
      if (!ready) check("ready_timeout", {31'b0, ready}, 32'd1);
   endtask

   task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
      int n;
      expect_req(rd, wr, a, d);
      memRead = rd; memWrite = wr; address = a; writeData = d;
      wait_ready(n);
      check("latency", n, L + 1);
      check("stall_in_done", {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      check("ready_one_cycle", {31'b0, ready}, 32'd0);
      check("data_cleared", readData, 32'd0);
      memRead = 0; memWrite = 0;
   endtask

   initial begin
      int n;
      logic [31:0] a;
      int r;
      @(posedge clk); #1;
      do_reset();
      repeat (10) begin
         @(posedge clk); #1;
         check("idle_outputs", {readData[30:0] | {29'b0, ready, err}, stall}, 32'd0);
      end
      do_req(1, 0, 32'h40, 0);
      do_req(0, 1, 32'h10, 32'hDEADBEEF);
      do_req(1, 0, 32'h10, 0);
      do_req(0, 1, 32'h404, 32'h12345678);
      do_req(1, 0, 32'h004, 0);
      do_req(0, 1, 32'h13, 32'h0BADF00D);
      do_req(1, 0, 32'h10, 0);
      do_req(1, 1, 32'h10, 32'h55555555);
      do_req(1, 0, 32'h10, 0);
      do_req(0, 1, 32'h24, 32'h11112222);
      // store aborted by reset the edge after accept
      memWrite = 1; address = 32'h20; writeData = 32'hAAAA5555;
      @(posedge clk); #1;
      rst = 1;
      check("stall_through_reset", {31'b0, stall}, 32'd1);
      @(posedge clk); #1;
      rst = 0;
      check("stall_after_reset", {31'b0, stall}, 32'd1);
      memWrite = 0;
      for (int i = 0; i < 256; i++) model[i] = 0;
      repeat (6) @(posedge clk);
      #1;
      do_req(1, 0, 32'h20, 0);
      do_req(1, 0, 32'h24, 0);
      // back-to-back loads held continuously: second ready follows L+2 edges later
      do_req(0, 1, 32'h30, 32'hCAFE0001);
      expect_req(1, 0, 32'h30, 0);
      expect_req(1, 0, 32'h30, 0);
      memRead = 1; address = 32'h30;
      wait_ready(n);
      check("b2b_first", n, L + 1);
      wait_ready(n);
      check("b2b_spacing", n, L + 2);
      @(posedge clk); #1;
      memRead = 0;
      check("b2b_ready_one_cycle", {31'b0, ready}, 32'd0);
      repeat (40) begin
         r = $urandom_range(0, 9);
         a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 2);
         if ($urandom_range(0, 5) == 0) a = a | $urandom_range(1, 3);
         do_req(r < 4 || r >= 8, r >= 4, a, $urandom);
      end
      repeat (5) @(posedge clk);
      #1 check("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
